// File: rtl/geri_yaz_hakemi.sv
// Register-file write-port arbiter for pipeline, delayed load data and gc; grant in cycle N writes in N+1.
// Backpressure: boru_durdur_o stalls the pipeline while a load is outstanding or a gc grant is forced; gc waits on gc_hazir_o.
module geri_yaz_hakemi #(
  parameter int GC_BEKLEME_SINIR = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        boru_gecerli_i,
  input  logic        boru_yazmaca_yaz_i,
  input  logic        boru_bellekten_oku_i,
  input  logic [4:0]  boru_hedef_yazmaci_i,
  input  logic [31:0] boru_veri_i,
  output logic        boru_durdur_o,
  input  logic        bellek_veri_hazir_i,
  input  logic [31:0] bellek_veri_i,
  input  logic        gc_veri_gecerli_i,
  input  logic [4:0]  gc_hedef_yazmaci_i,
  input  logic [31:0] gc_okunan_veri_i,
  output logic        gc_hazir_o,
  output logic        bekleyen_gecerli_o,
  output logic [4:0]  bekleyen_yazmaci_o,
  output logic        yazmaca_yaz_o,
  output logic [4:0]  hedef_yazmaci_o,
  output logic [31:0] yazmac_veri_o
);

  typedef enum logic {BOSTA, YUKLEME_BEKLE} durum_t;

  localparam logic [3:0] SINIR = 4'(GC_BEKLEME_SINIR);

  durum_t      durum, durum_sonraki;
  logic [4:0]  bekleyen_rd;
  logic        bekleyen_yaz;
  logic [3:0]  gc_sayac;

  logic        izin;
  logic        izin_yaz;
  logic [4:0]  izin_rd;
  logic [31:0] izin_veri;
  logic        yukleme_kabul;

  always_comb begin
    durum_sonraki = durum;
    boru_durdur_o = 1'b0;
    gc_hazir_o    = 1'b0;
    izin          = 1'b0;
    izin_yaz      = 1'b0;
    izin_rd       = 5'd0;
    izin_veri     = 32'd0;
    yukleme_kabul = 1'b0;

    case (durum)
      BOSTA: begin
        if (gc_sayac == SINIR && gc_veri_gecerli_i) begin
          gc_hazir_o    = 1'b1;
          boru_durdur_o = boru_gecerli_i;
        end else if (boru_gecerli_i && boru_bellekten_oku_i) begin
          if (bellek_veri_hazir_i) begin
            izin      = 1'b1;
            izin_yaz  = boru_yazmaca_yaz_i;
            izin_rd   = boru_hedef_yazmaci_i;
            izin_veri = bellek_veri_i;
          end else begin
            // Port stays free while the load is in flight, so gc may use it.
            yukleme_kabul = 1'b1;
            durum_sonraki = YUKLEME_BEKLE;
            gc_hazir_o    = gc_veri_gecerli_i;
          end
        end else if (boru_gecerli_i && boru_yazmaca_yaz_i) begin
          izin      = 1'b1;
          izin_yaz  = 1'b1;
          izin_rd   = boru_hedef_yazmaci_i;
          izin_veri = boru_veri_i;
        end else begin
          gc_hazir_o = gc_veri_gecerli_i;
        end
      end
      YUKLEME_BEKLE: begin
        boru_durdur_o = boru_gecerli_i;
        if (bellek_veri_hazir_i) begin
          izin          = 1'b1;
          izin_yaz      = bekleyen_yaz;
          izin_rd       = bekleyen_rd;
          izin_veri     = bellek_veri_i;
          durum_sonraki = BOSTA;
        end else begin
          gc_hazir_o = gc_veri_gecerli_i;
        end
      end
      default: durum_sonraki = BOSTA;
    endcase

    if (gc_hazir_o) begin
      izin      = 1'b1;
      izin_yaz  = 1'b1;
      izin_rd   = gc_hedef_yazmaci_i;
      izin_veri = gc_okunan_veri_i;
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      durum           <= BOSTA;
      bekleyen_rd     <= 5'd0;
      bekleyen_yaz    <= 1'b0;
      gc_sayac        <= 4'd0;
      yazmaca_yaz_o   <= 1'b0;
      hedef_yazmaci_o <= 5'd0;
      yazmac_veri_o   <= 32'd0;
    end else begin
      durum <= durum_sonraki;
      if (yukleme_kabul) begin
        bekleyen_rd  <= boru_hedef_yazmaci_i;
        bekleyen_yaz <= boru_yazmaca_yaz_i;
      end
      if (gc_hazir_o || !gc_veri_gecerli_i) begin
        gc_sayac <= 4'd0;
      end else if (gc_sayac != SINIR) begin
        gc_sayac <= gc_sayac + 4'd1;
      end
      // x0 is hardwired zero, so writes to it are dropped here.
      yazmaca_yaz_o <= izin && izin_yaz && (izin_rd != 5'd0);
      if (izin) begin
        hedef_yazmaci_o <= izin_rd;
        yazmac_veri_o   <= izin_veri;
      end
    end
  end

  assign bekleyen_gecerli_o = (durum == YUKLEME_BEKLE);
  assign bekleyen_yazmaci_o = bekleyen_rd;

endmodule

// File: tb/tb_geri_yaz_hakemi.sv
// Directed bench for geri_yaz_hakemi: per-cycle vector table plus starvation and reset sequences.
module tb_geri_yaz_hakemi;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        boru_gecerli_i, boru_yazmaca_yaz_i, boru_bellekten_oku_i;
  logic [4:0]  boru_hedef_yazmaci_i;
  logic [31:0] boru_veri_i;
  logic        boru_durdur_o;
  logic        bellek_veri_hazir_i;
  logic [31:0] bellek_veri_i;
  logic        gc_veri_gecerli_i;
  logic [4:0]  gc_hedef_yazmaci_i;
  logic [31:0] gc_okunan_veri_i;
  logic        gc_hazir_o;
  logic        bekleyen_gecerli_o;
  logic [4:0]  bekleyen_yazmaci_o;
  logic        yazmaca_yaz_o;
  logic [4:0]  hedef_yazmaci_o;
  logic [31:0] yazmac_veri_o;

  int checks = 0;
  int errors = 0;

  geri_yaz_hakemi #(.GC_BEKLEME_SINIR(4)) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .boru_gecerli_i(boru_gecerli_i), .boru_yazmaca_yaz_i(boru_yazmaca_yaz_i),
    .boru_bellekten_oku_i(boru_bellekten_oku_i), .boru_hedef_yazmaci_i(boru_hedef_yazmaci_i),
    .boru_veri_i(boru_veri_i), .boru_durdur_o(boru_durdur_o),
    .bellek_veri_hazir_i(bellek_veri_hazir_i), .bellek_veri_i(bellek_veri_i),
    .gc_veri_gecerli_i(gc_veri_gecerli_i), .gc_hedef_yazmaci_i(gc_hedef_yazmaci_i),
    .gc_okunan_veri_i(gc_okunan_veri_i), .gc_hazir_o(gc_hazir_o),
    .bekleyen_gecerli_o(bekleyen_gecerli_o), .bekleyen_yazmaci_o(bekleyen_yazmaci_o),
    .yazmaca_yaz_o(yazmaca_yaz_o), .hedef_yazmaci_o(hedef_yazmaci_o),
    .yazmac_veri_o(yazmac_veri_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic        gv, yaz, oku;
    logic [4:0]  rd;
    logic [31:0] d;
    logic        mh;
    logic [31:0] mv;
    logic        gcv;
    logic [4:0]  gcrd;
    logic [31:0] gcd;
    logic        e_dur, e_gch, e_bg;
    logic [4:0]  e_brd;
    logic        e_we;
    logic [4:0]  e_wrd;
    logic [31:0] e_wv;
  } vec_t;

  function automatic vec_t v(
    input logic gv, input logic yaz, input logic oku, input logic [4:0] rd, input logic [31:0] d,
    input logic mh, input logic [31:0] mv, input logic gcv, input logic [4:0] gcrd, input logic [31:0] gcd,
    input logic e_dur, input logic e_gch, input logic e_bg, input logic [4:0] e_brd,
    input logic e_we, input logic [4:0] e_wrd, input logic [31:0] e_wv);
    vec_t r;
    r.gv = gv; r.yaz = yaz; r.oku = oku; r.rd = rd; r.d = d;
    r.mh = mh; r.mv = mv; r.gcv = gcv; r.gcrd = gcrd; r.gcd = gcd;
    r.e_dur = e_dur; r.e_gch = e_gch; r.e_bg = e_bg; r.e_brd = e_brd;
    r.e_we = e_we; r.e_wrd = e_wrd; r.e_wv = e_wv;
    return r;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic drive(input logic gv, input logic yaz, input logic oku, input logic [4:0] rd,
                       input logic [31:0] d, input logic mh, input logic [31:0] mv,
                       input logic gcv, input logic [4:0] gcrd, input logic [31:0] gcd);
    boru_gecerli_i = gv; boru_yazmaca_yaz_i = yaz; boru_bellekten_oku_i = oku;
    boru_hedef_yazmaci_i = rd; boru_veri_i = d;
    bellek_veri_hazir_i = mh; bellek_veri_i = mv;
    gc_veri_gecerli_i = gcv; gc_hedef_yazmaci_i = gcrd; gc_okunan_veri_i = gcd;
  endtask

  task automatic idle();
    drive(0, 0, 0, 5'd0, 32'd0, 0, 32'd0, 0, 5'd0, 32'd0);
  endtask

  vec_t tbl[21];

  initial begin
    // Each row: inputs for this cycle, expected combinational outputs this cycle,
    // and registered outputs resulting from the previous row's grant.
    tbl[0]  = v(1,1,0, 5'd5, 32'h1234,     0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[1]  = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  1, 5'd5, 32'h1234);
    tbl[2]  = v(1,1,1, 5'd7, 0,            0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[3]  = v(1,0,0, 0, 0,               0, 0,            0, 0, 0,        1,0,1, 5'd7, 0, 0, 0);
    tbl[4]  = v(1,0,0, 0, 0,               0, 0,            0, 0, 0,        1,0,1, 5'd7, 0, 0, 0);
    tbl[5]  = v(1,0,0, 0, 0,               0, 0,            0, 0, 0,        1,0,1, 5'd7, 0, 0, 0);
    tbl[6]  = v(1,0,0, 0, 0,               1, 32'hDEADBEEF, 0, 0, 0,        1,0,1, 5'd7, 0, 0, 0);
    tbl[7]  = v(1,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  1, 5'd7, 32'hDEADBEEF);
    tbl[8]  = v(1,1,1, 5'd3, 0,            1, 32'h55AA,     0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[9]  = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  1, 5'd3, 32'h55AA);
    tbl[10] = v(1,1,1, 5'd10, 0,           0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[11] = v(0,0,0, 0, 0,               0, 0,            1, 5'd9, 32'hAA, 0,1,1, 5'd10, 0, 0, 0);
    tbl[12] = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,1, 5'd10, 1, 5'd9, 32'hAA);
    tbl[13] = v(0,0,0, 0, 0,               1, 32'h77,       1, 5'd11, 32'hBB, 0,0,1, 5'd10, 0, 0, 0);
    tbl[14] = v(0,0,0, 0, 0,               0, 0,            1, 5'd11, 32'hBB, 0,1,0, 0,  1, 5'd10, 32'h77);
    tbl[15] = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  1, 5'd11, 32'hBB);
    tbl[16] = v(0,0,0, 0, 0,               1, 32'h1234,     0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[17] = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[18] = v(1,1,1, 5'd0, 0,            0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);
    tbl[19] = v(1,0,0, 0, 0,               1, 32'h99,       0, 0, 0,        1,0,1, 5'd0, 0, 0, 0);
    tbl[20] = v(0,0,0, 0, 0,               0, 0,            0, 0, 0,        0,0,0, 0,  0, 0, 0);

    rst_i = 1'b0;
    idle();
    repeat (3) @(negedge clk_i);
    #2;
    chk("reset_yaz", {31'd0, yazmaca_yaz_o}, 32'd0);
    chk("reset_hedef", {27'd0, hedef_yazmaci_o}, 32'd0);
    chk("reset_veri", yazmac_veri_o, 32'd0);
    chk("reset_bekleyen", {31'd0, bekleyen_gecerli_o}, 32'd0);
    chk("reset_bekleyen_rd", {27'd0, bekleyen_yazmaci_o}, 32'd0);
    chk("reset_durdur", {31'd0, boru_durdur_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;

    for (int i = 0; i < 21; i++) begin
      @(negedge clk_i);
      drive(tbl[i].gv, tbl[i].yaz, tbl[i].oku, tbl[i].rd, tbl[i].d,
            tbl[i].mh, tbl[i].mv, tbl[i].gcv, tbl[i].gcrd, tbl[i].gcd);
      #2;
      chk($sformatf("v%0d_durdur", i), {31'd0, boru_durdur_o}, {31'd0, tbl[i].e_dur});
      chk($sformatf("v%0d_gc_hazir", i), {31'd0, gc_hazir_o}, {31'd0, tbl[i].e_gch});
      chk($sformatf("v%0d_bekleyen", i), {31'd0, bekleyen_gecerli_o}, {31'd0, tbl[i].e_bg});
      if (tbl[i].e_bg)
        chk($sformatf("v%0d_bekleyen_rd", i), {27'd0, bekleyen_yazmaci_o}, {27'd0, tbl[i].e_brd});
      chk($sformatf("v%0d_yaz", i), {31'd0, yazmaca_yaz_o}, {31'd0, tbl[i].e_we});
      if (tbl[i].e_we) begin
        chk($sformatf("v%0d_hedef", i), {27'd0, hedef_yazmaci_o}, {27'd0, tbl[i].e_wrd});
        chk($sformatf("v%0d_veri", i), yazmac_veri_o, tbl[i].e_wv);
      end
    end

    // gc starvation: ALU writes back to back, forced gc grant on the fifth cycle.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk_i);
      drive(1, 1, 0, 5'(i + 1), 32'h100 + 32'(i), 0, 0, 1, 5'd12, 32'hCC);
      #2;
      chk($sformatf("aclik%0d_gc_hazir", i), {31'd0, gc_hazir_o}, {31'd0, (i == 4)});
      chk($sformatf("aclik%0d_durdur", i), {31'd0, boru_durdur_o}, {31'd0, (i == 4)});
      chk($sformatf("aclik%0d_yaz", i), {31'd0, yazmaca_yaz_o}, {31'd0, (i != 0)});
      if (i != 0) begin
        chk($sformatf("aclik%0d_hedef", i), {27'd0, hedef_yazmaci_o}, 32'(i));
        chk($sformatf("aclik%0d_veri", i), yazmac_veri_o, 32'h100 + 32'(i - 1));
      end
    end
    @(negedge clk_i);
    drive(1, 1, 0, 5'd5, 32'h104, 0, 0, 0, 0, 0);
    #2;
    chk("aclik_gc_yaz", {31'd0, yazmaca_yaz_o}, 32'd1);
    chk("aclik_gc_hedef", {27'd0, hedef_yazmaci_o}, 32'd12);
    chk("aclik_gc_veri", yazmac_veri_o, 32'hCC);
    chk("aclik_sonra_durdur", {31'd0, boru_durdur_o}, 32'd0);
    @(negedge clk_i);
    idle();
    #2;
    chk("aclik_boru_hedef", {27'd0, hedef_yazmaci_o}, 32'd5);
    chk("aclik_boru_veri", yazmac_veri_o, 32'h104);

    // x0 write suppression, then reset while a load is outstanding.
    @(negedge clk_i);
    drive(1, 1, 0, 5'd0, 32'hFFFF, 0, 0, 0, 0, 0);
    @(negedge clk_i);
    drive(1, 1, 1, 5'd6, 0, 0, 0, 0, 0, 0);
    #2;
    chk("x0_yaz", {31'd0, yazmaca_yaz_o}, 32'd0);
    @(negedge clk_i);
    idle();
    #2;
    chk("mid_bekleyen", {31'd0, bekleyen_gecerli_o}, 32'd1);
    chk("mid_bekleyen_rd", {27'd0, bekleyen_yazmaci_o}, 32'd6);
    rst_i = 1'b0;
    #2;
    chk("mid_reset_bekleyen", {31'd0, bekleyen_gecerli_o}, 32'd0);
    @(negedge clk_i);
    rst_i = 1'b1;
    drive(1, 0, 0, 0, 0, 1, 32'h5555, 0, 0, 0);
    #2;
    chk("reset_sonra_durdur", {31'd0, boru_durdur_o}, 32'd0);
    @(negedge clk_i);
    idle();
    #2;
    chk("reset_sonra_yaz", {31'd0, yazmaca_yaz_o}, 32'd0);
    chk("reset_sonra_bekleyen", {31'd0, bekleyen_gecerli_o}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
